// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the sequential signed divider
//               (div_seq / div_step). Optional remainder output is built when
//               the DIV_REM_EN macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

    // Default operand/result width of the divider
    localparam int WIDTH_DEFAULT = 8;

    // Quotient reported for a divide by zero (all ones, i.e. -1)
    localparam logic [WIDTH_DEFAULT-1:0] DIVZERO_Q = '1;

    // Iteration counter width: must hold 0 .. WIDTH-1 with headroom
    localparam int CNT_W = $clog2(WIDTH_DEFAULT) + 1;

    // Controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module      : div_step
// Description : One combinational restoring-division step. Shifts the next
//               dividend bit into the partial remainder and trial-subtracts
//               the divisor magnitude; keeps the difference when it is
//               non-negative. Used identically whether or not DIV_REM_EN is
//               defined.
// Revision    : 1.0 - initial release
// ============================================================================
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] prem_i,   // partial remainder (always < divisor)
    input  logic             dbit_i,   // next dividend bit, MSB first
    input  logic [WIDTH-1:0] bmag_i,   // divisor magnitude
    output logic [WIDTH-1:0] prem_o,   // next partial remainder
    output logic             qbit_o    // quotient bit produced by this step
);

    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_trial;

    // Shift, trial subtract, and restore when the difference went negative.
    // The shifted value is below 2*divisor (or below 2^WIDTH when the divisor
    // is zero), so the top bit of the WIDTH+1 bit difference is its sign.
    always_comb begin
        w_shift = {prem_i, dbit_i};
        w_trial = w_shift - {1'b0, bmag_i};
        qbit_o  = ~w_trial[WIDTH];
        prem_o  = qbit_o ? w_trial[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end

endmodule : div_step
`default_nettype wire

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Sequential signed integer divider, one restoring step per
//               clock, truncating toward zero. Start is sampled in IDLE only;
//               the result appears with a one-cycle Done pulse WIDTH cycles
//               later. Define DIV_REM_EN to build the remainder output;
//               without it Rem is tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Rem,
    output logic             DivZero
);

    localparam int             CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_t state_q, state_d;

    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;     // dividend magnitude, shifted out MSB first
    logic [WIDTH-1:0] bmag_q;    // divisor magnitude
    logic [WIDTH-2:0] quo_q;     // quotient bits gathered so far
    logic [WIDTH-1:0] prem_q;    // partial remainder
    logic             neg_q;     // quotient sign: sign(A) xor sign(B)
    logic             bzero_q;   // divisor was zero
    logic [WIDTH-1:0] q_q;
    logic             divz_q;

    logic [WIDTH-1:0] w_amag;
    logic [WIDTH-1:0] w_bmag;
    logic [WIDTH-1:0] w_prem_next;
    logic             w_qbit;
    logic [WIDTH-1:0] w_qmag;
    logic [WIDTH-1:0] w_qres;
    logic             w_last;

    // Magnitudes of the incoming operands; -2^(WIDTH-1) maps to 2^(WIDTH-1)
    assign w_amag = A[WIDTH-1] ? (~A + 1'b1) : A;
    assign w_bmag = B[WIDTH-1] ? (~B + 1'b1) : B;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .prem_i (prem_q),
        .dbit_i (dvd_q[WIDTH-1]),
        .bmag_i (bmag_q),
        .prem_o (w_prem_next),
        .qbit_o (w_qbit)
    );

    assign w_last = (cnt_q == LAST);
    assign w_qmag = {quo_q, w_qbit};

    // Final quotient: forced to -1 on divide by zero, otherwise sign-corrected.
    // The -2^(WIDTH-1) / -1 case wraps to 2^(WIDTH-1) naturally.
    assign w_qres = bzero_q ? {WIDTH{1'b1}}
                            : (neg_q ? (~w_qmag + 1'b1) : w_qmag);

    // State register
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and status outputs decoded from the state register
    always_comb begin
        state_d = state_q;
        Busy    = (state_q != IDLE);
        Done    = 1'b0;
        case (state_q)
            IDLE: if (Start) state_d = CALC;
            CALC: if (w_last) state_d = DONE;
            DONE: begin
                Done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and quotient/flag result registers
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            cnt_q   <= '0;
            dvd_q   <= '0;
            bmag_q  <= '0;
            quo_q   <= '0;
            prem_q  <= '0;
            neg_q   <= 1'b0;
            bzero_q <= 1'b0;
            q_q     <= '0;
            divz_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        dvd_q   <= w_amag;
                        bmag_q  <= w_bmag;
                        neg_q   <= A[WIDTH-1] ^ B[WIDTH-1];
                        bzero_q <= (B == '0);
                        cnt_q   <= '0;
                        quo_q   <= '0;
                        prem_q  <= '0;
                    end
                end
                CALC: begin
                    prem_q <= w_prem_next;
                    quo_q  <= w_qmag[WIDTH-2:0];
                    dvd_q  <= {dvd_q[WIDTH-2:0], 1'b0};
                    cnt_q  <= cnt_q + 1'b1;
                    if (w_last) begin
                        q_q    <= w_qres;
                        divz_q <= bzero_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q       = q_q;
    assign DivZero = divz_q;

`ifdef DIV_REM_EN
    logic             sign_a_q;
    logic [WIDTH-1:0] rem_q;

    // Remainder takes the dividend's sign. With a zero divisor every trial
    // subtract succeeds, leaving |A| in the partial remainder, so this
    // sign correction returns A itself.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            sign_a_q <= 1'b0;
            rem_q    <= '0;
        end else begin
            if (state_q == IDLE && Start) begin
                sign_a_q <= A[WIDTH-1];
            end
            if (state_q == CALC && w_last) begin
                rem_q <= sign_a_q ? (~w_prem_next + 1'b1) : w_prem_next;
            end
        end
    end

    assign Rem = rem_q;
`else
    assign Rem = '0;
`endif

endmodule : div_seq
`default_nettype wire

// File: doc/div_seq.md
# div_seq

Sequential signed integer divider for the picoMips datapath. It is the inverse companion of the multiplier-based ALU ops. It accepts a dividend and divisor on a start pulse and runs one restoring shift/subtract step per clock. It returns a quotient and remainder with a one-cycle done pulse, so the control unit can stall on Busy for DIV instructions.

## Interface
- WIDTH, 8, operand/result width; iteration count equals WIDTH
- Clock  input  1  rising-edge clock
- nReset  input  1  asynchronous, active-low reset
- Start  input  1  request; sampled only in IDLE
- A  input  WIDTH  signed dividend, sampled with Start
- B  input  WIDTH  signed divisor, sampled with Start
- Busy  output  1  high whenever state is not IDLE
- Done  output  1  one-cycle pulse; Q/Rem/DivZero valid from this cycle
- Q  output  WIDTH  signed quotient, registered, held until next result
- Rem  output  WIDTH  signed remainder, registered, held until next result
- DivZero  output  1  registered; set with a result whose B was 0

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - Start=1 latches |A| and |B| as WIDTH-bit unsigned magnitudes (|−128| = 8'h80).
  - Also latches sign(A), sign(A) XOR sign(B), and B==0; clears the iteration counter; goes to CALC.
  - Start=0 stays in IDLE.
- CALC, one restoring step per cycle:
  - Partial remainder is WIDTH+1 bits: shift in the next dividend MSB, trial-subtract the divisor magnitude.
  - Keep the result if it is non-negative and shift a 1 into the quotient; otherwise shift in 0.
  - After WIDTH steps, sign-correct and load Q/Rem/DivZero, then go to DONE.
- Sign rules:
  - Truncation toward zero.
  - Q is negated if the signs differ.
  - Rem takes the sign of A.
  - All arithmetic is modulo 2^WIDTH.
- Divide by zero: the iteration count is unchanged (fixed latency). Result is forced to Q = all-ones (−1), Rem = A, DivZero = 1.
- Overflow: −128 / −1 gives Q = 8'h80 (wraps), Rem = 0, DivZero = 0. No separate flag.
- DONE: Done=1 for exactly one cycle, then IDLE.
- Start is ignored in CALC and DONE: no queuing, and the operands are not re-sampled.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Q=0, Rem=0, DivZero=0, internal registers 0.
- Latency: Start sampled at edge k → Done high in the cycle after edge k+WIDTH (8 cycles for WIDTH=8).
- Busy goes high after edge k and low after edge k+WIDTH+1.
- Throughput: one result per WIDTH+2 cycles. Start asserted in the first cycle after the DONE cycle (state IDLE) is accepted.
- Q/Rem/DivZero change only on the edge entering DONE, and are stable at all other times.
- nReset asserted mid-operation aborts immediately:
  - All outputs return to their reset values asynchronously.
  - No Done is produced for the aborted request.
- No combinational path from Start/A/B to any output.

## Configuration
- DIV_REM_EN defined: the Rem output register and remainder sign-correction are built.
- DIV_REM_EN undefined: Rem is tied to 0 and its output register and sign-correction logic are removed.
  - The internal partial remainder is still required by the algorithm.
  - Q, DivZero and timing are identical in both builds.

## Structure
- Shared package div_pkg:
  - typedef enum for the state (IDLE, CALC, DONE)
  - WIDTH default constant
  - DIVZERO_Q constant (all-ones)
  - iteration-counter width constant ($clog2(WIDTH)+1)
- Sub-module div_step: combinational single restoring step.
  - Inputs: partial remainder, dividend bit, divisor magnitude.
  - Outputs: next partial remainder, quotient bit.
  - Instantiated once in div_seq and reused every CALC cycle.

## Test plan
- A=100, B=7, Start one cycle → Done exactly 8 cycles later, Q=14 (8'h0E), Rem=2, DivZero=0, Busy high for 9 cycles.
- A=−100, B=7 → Q=8'hF2 (−14), Rem=8'hFE (−2). A=100, B=−7 → Q=8'hF2, Rem=2. A=−100, B=−7 → Q=14, Rem=8'hFE.
- A=25, B=0 → after 8 cycles Q=8'hFF, Rem=25, DivZero=1. A next request 6/3 → Q=2, Rem=0, DivZero=0.
- A=−128, B=−1 → Q=8'h80, Rem=0, DivZero=0. A=−128, B=1 → Q=8'h80, Rem=0.
- A=9, B=2 started; Start held high with A=50, B=5 for the whole operation → single Done with Q=4, Rem=1; second request accepted only once IDLE. Then nReset low at CALC cycle 4 → Busy=0, Q=Rem=0 at once, no Done.
- Build without DIV_REM_EN: A=100, B=7 → Q=14, Rem=0, same latency.
